// File: rtl/scan_bist_ctrl.sv
// scan_bist_ctrl: BIST sequencer for the scan ALU wrapper.
// An LFSR generates 8-bit {A,B} patterns. Each pattern is shifted MSB first
// into the wrapper's scan chain, and the ALU response is then captured into
// an 8-bit MISR. The final MISR value is compared against GOLDEN_SIG.
// Optional build macro: SCAN_BIST_OUTCOMP_EN. When it is defined, the serial
// unload from scan_out_in is also folded into the MISR on every shift cycle.
module scan_bist_ctrl #(
  parameter int         CHAIN_LEN    = 8,
  parameter int         NUM_PATTERNS = 16,
  parameter logic [7:0] LFSR_SEED    = 8'hA5,
  parameter logic [7:0] GOLDEN_SIG   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       scan_enable,
  output logic       scan_in,
  output logic [2:0] opcode,
  input  logic [3:0] result_in,
  input  logic       zero_flag_in,
  input  logic       scan_out_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] signature,
  output logic       pass
);

  // The bit counter must hold CHAIN_LEN-1.
  // The pattern counter must hold NUM_PATTERNS, and it must be at least
  // 3 bits wide so it can drive the opcode.
  localparam int BW     = $clog2(CHAIN_LEN + 1);
  localparam int PW_RAW = $clog2(NUM_PATTERNS) + 1;
  localparam int PW     = (PW_RAW < 3) ? 3 : PW_RAW;

  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] LAST_PAT = PW'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      lfsr_reg, lfsr_next;
  logic [7:0]      misr_reg, misr_next;
  logic [BW-1:0]   bitcnt_reg, bitcnt_next;
  logic [PW-1:0]   patcnt_reg, patcnt_next;
  logic [BW-1:0]   bit_idx;
  logic [7:0]      lfsr_sel;

  // The LFSR and the MISR share the same feedback polynomial.
  // The taps are bits 7, 5, 4 and 3, and new bits shift in at the LSB.
  function automatic logic [7:0] poly_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

`ifndef SCAN_BIST_OUTCOMP_EN
  // Without output compaction, the wrapper's scan_out is not observed.
  logic unused_scan_out;
  assign unused_scan_out = scan_out_in;
`endif

  // State register, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      lfsr_reg   <= LFSR_SEED;
      misr_reg   <= 8'h00;
      bitcnt_reg <= '0;
      patcnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      lfsr_reg   <= lfsr_next;
      misr_reg   <= misr_next;
      bitcnt_reg <= bitcnt_next;
      patcnt_reg <= patcnt_next;
    end
  end

  // Next-state logic. The start input is only honoured in IDLE and DONE.
  always_comb begin
    state_next  = state_reg;
    lfsr_next   = lfsr_reg;
    misr_next   = misr_reg;
    bitcnt_next = bitcnt_reg;
    patcnt_next = patcnt_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next  = SHIFT;
          lfsr_next   = LFSR_SEED;
          misr_next   = 8'h00;
          bitcnt_next = '0;
          patcnt_next = '0;
        end
      end
      SHIFT: begin
`ifdef SCAN_BIST_OUTCOMP_EN
        misr_next = misr_reg ^ {scan_out_in, 7'b0};
`endif
        if (bitcnt_reg == LAST_BIT) begin
          bitcnt_next = '0;
          state_next  = CAPTURE;
        end else begin
          bitcnt_next = bitcnt_reg + BW'(1);
        end
      end
      CAPTURE: begin
        misr_next   = poly_step(misr_reg) ^ {3'b000, zero_flag_in, result_in};
        lfsr_next   = poly_step(lfsr_reg);
        patcnt_next = patcnt_reg + PW'(1);
        state_next  = (patcnt_reg == LAST_PAT) ? DONE : SHIFT;
      end
      default: state_next = IDLE;
    endcase
  end

  // The pattern is sent MSB first.
  // Shifting the LFSR down by bit_idx brings the selected bit to position 0.
  assign bit_idx  = LAST_BIT - bitcnt_reg;
  assign lfsr_sel = lfsr_reg >> bit_idx;

  // The outputs are pure decodes of registered state.
  // None of them has a combinational path from an input.
  always_comb begin
    busy        = (state_reg == SHIFT) || (state_reg == CAPTURE);
    done        = (state_reg == DONE);
    scan_enable = busy;
    scan_in     = (state_reg == SHIFT) ? lfsr_sel[0] : 1'b0;
    opcode      = busy ? patcnt_reg[2:0] : 3'b000;
    signature   = misr_reg;
    pass        = done && (misr_reg == GOLDEN_SIG);
  end

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Directed bench for scan_bist_ctrl.
// It drives two instances from the same inputs:
//   dut_a runs one pattern per run and has golden signature 8'h10.
//   dut_b runs two patterns per run and has golden signature 8'h00.
// The ALU is stubbed by the bench through result_in and zero_flag_in.
// Note: scan_out_in is held at 0, so expected signatures do not depend on
// whether output compaction is built in.
module tb_scan_bist_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] result_in;
  logic       zero_flag_in;
  logic       scan_out_in;

  logic       se_a, si_a, busy_a, done_a, pass_a;
  logic [2:0] op_a;
  logic [7:0] sig_a;
  logic       se_b, si_b, busy_b, done_b, pass_b;
  logic [2:0] op_b;
  logic [7:0] sig_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_bist_ctrl #(.CHAIN_LEN(8), .NUM_PATTERNS(1), .LFSR_SEED(8'hA5), .GOLDEN_SIG(8'h10)) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .scan_enable(se_a), .scan_in(si_a), .opcode(op_a),
    .result_in(result_in), .zero_flag_in(zero_flag_in), .scan_out_in(scan_out_in),
    .busy(busy_a), .done(done_a), .signature(sig_a), .pass(pass_a)
  );

  scan_bist_ctrl #(.CHAIN_LEN(8), .NUM_PATTERNS(2), .LFSR_SEED(8'hA5), .GOLDEN_SIG(8'h00)) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .scan_enable(se_b), .scan_in(si_b), .opcode(op_b),
    .result_in(result_in), .zero_flag_in(zero_flag_in), .scan_out_in(scan_out_in),
    .busy(busy_b), .done(done_b), .signature(sig_b), .pass(pass_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then wait 1 time unit so outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one full BIST pass on both instances, checking cycle by cycle.
  // hold: number of cycles to keep start high after it has been accepted.
  task automatic run(input int id, input logic [3:0] res, input logic zf, input int hold,
                     input logic [7:0] exp_sa, input logic exp_pa, input logic [7:0] exp_sb);
    logic [7:0] pat1;
    logic [7:0] pat2;
    pat1 = 8'hA5;
    pat2 = 8'h4A;
    result_in    = res;
    zero_flag_in = zf;
    start        = 1'b1;
    step();
    start = (hold > 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("r%0d_p1_si_a[%0d]", id, i), 32'(si_a), 32'(pat1[7-i]));
      chk($sformatf("r%0d_p1_si_b[%0d]", id, i), 32'(si_b), 32'(pat1[7-i]));
      chk($sformatf("r%0d_p1_se_a[%0d]", id, i), 32'(se_a), 32'd1);
      chk($sformatf("r%0d_p1_busy_b[%0d]", id, i), 32'(busy_b), 32'd1);
      chk($sformatf("r%0d_p1_op_b[%0d]", id, i), 32'(op_b), 32'd0);
      start = (i + 1 < hold);
      step();
    end
    start = 1'b0;
    chk($sformatf("r%0d_cap_se_a", id), 32'(se_a), 32'd1);
    chk($sformatf("r%0d_cap_si_a", id), 32'(si_a), 32'd0);
    chk($sformatf("r%0d_cap_done_a", id), 32'(done_a), 32'd0);
    chk($sformatf("r%0d_cap_op_a", id), 32'(op_a), 32'd0);
    step();
    chk($sformatf("r%0d_done_a", id), 32'(done_a), 32'd1);
    chk($sformatf("r%0d_busy_a", id), 32'(busy_a), 32'd0);
    chk($sformatf("r%0d_se_a_done", id), 32'(se_a), 32'd0);
    chk($sformatf("r%0d_sig_a", id), 32'(sig_a), 32'(exp_sa));
    chk($sformatf("r%0d_pass_a", id), 32'(pass_a), 32'(exp_pa));
    chk($sformatf("r%0d_done_b_early", id), 32'(done_b), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("r%0d_p2_si_b[%0d]", id, i), 32'(si_b), 32'(pat2[7-i]));
      chk($sformatf("r%0d_p2_op_b[%0d]", id, i), 32'(op_b), 32'd1);
      chk($sformatf("r%0d_p2_se_b[%0d]", id, i), 32'(se_b), 32'd1);
      step();
    end
    chk($sformatf("r%0d_cap2_se_b", id), 32'(se_b), 32'd1);
    chk($sformatf("r%0d_cap2_si_b", id), 32'(si_b), 32'd0);
    step();
    chk($sformatf("r%0d_done_b", id), 32'(done_b), 32'd1);
    chk($sformatf("r%0d_sig_b", id), 32'(sig_b), 32'(exp_sb));
    chk($sformatf("r%0d_pass_b", id), 32'(pass_b), 32'd0);
    chk($sformatf("r%0d_hold_done_a", id), 32'(done_a), 32'd1);
    chk($sformatf("r%0d_hold_sig_a", id), 32'(sig_a), 32'(exp_sa));
    $display("run %0d: res=%h zf=%0d sig_a=%h pass_a=%0d sig_b=%h pass_b=%0d",
             id, res, zf, sig_a, pass_a, sig_b, pass_b);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_se_a"}, 32'(se_a), 32'd0);
    chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
    chk({tag, "_done_a"}, 32'(done_a), 32'd0);
    chk({tag, "_sig_a"}, 32'(sig_a), 32'd0);
    chk({tag, "_pass_a"}, 32'(pass_a), 32'd0);
    chk({tag, "_op_a"}, 32'(op_a), 32'd0);
    chk({tag, "_si_a"}, 32'(si_a), 32'd0);
    chk({tag, "_se_b"}, 32'(se_b), 32'd0);
    chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
    chk({tag, "_sig_b"}, 32'(sig_b), 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    result_in    = 4'h0;
    zero_flag_in = 1'b1;
    scan_out_in  = 1'b0;
    step();
    step();
    chk_cleared("rst");
    reset = 1'b1;
    step();
    chk("idle_busy_a", 32'(busy_a), 32'd0);

    // Run 1: the stub returns result 0 with the zero flag set.
    // dut_a: misr = 0 ^ 8'h10 = 8'h10, which matches its golden value, so it passes.
    // dut_b: poly_step(8'h10) = 8'h21, then 8'h21 ^ 8'h10 = 8'h31.
    run(1, 4'h0, 1'b1, 0, 8'h10, 1'b1, 8'h31);

    // Run 2 restarts from DONE. The stub returns result 5 with the zero flag clear.
    // dut_a: misr = 8'h05.
    // dut_b: poly_step(8'h05) = 8'h0A, then 8'h0A ^ 8'h05 = 8'h0F.
    run(2, 4'h5, 1'b0, 0, 8'h05, 1'b0, 8'h0F);

    // Run 3 holds start high for 5 busy cycles; the controller must ignore it.
    // It uses the same stub as run 1, so the signatures must match run 1 exactly.
    run(3, 4'h0, 1'b1, 5, 8'h10, 1'b1, 8'h31);

    // Assert reset partway through SHIFT.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("mid_busy_a", 32'(busy_a), 32'd1);
    reset = 1'b0;
    step();
    chk_cleared("midrst");
    reset = 1'b1;
    step();
    chk("post_rst_idle_a", 32'(busy_a), 32'd0);
    $display("reset-mid-shift: busy_a=%0d sig_a=%h sig_b=%h", busy_a, sig_a, sig_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_bist_ctrl.md
Name: scan_bist_ctrl

Overview:
On-chip BIST controller that sits directly upstream and downstream of the scan ALU wrapper. It drives that wrapper's scan_in, scan_enable and opcode inputs. Pseudo-random 8-bit {A,B} patterns from an LFSR are shifted serially into the scan chain. The ALU response (result, zero_flag) is compacted into an 8-bit MISR signature and compared against a golden value.

Parameters:
CHAIN_LEN, 8, scan chain length in bits; shift cycles per pattern.
NUM_PATTERNS, 16, patterns applied per run (1..256).
LFSR_SEED, 8'hA5, LFSR value at run start; must be nonzero.
GOLDEN_SIG, 8'h00, expected final MISR signature.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
start  input  1  run request; sampled only in IDLE or DONE.
scan_enable  output  1  drives the ALU wrapper's scan_enable.
scan_in  output  1  serial pattern bit to the wrapper.
opcode  output  3  ALU opcode for the current pattern.
result_in  input  4  ALU result from the wrapper.
zero_flag_in  input  1  ALU zero flag from the wrapper.
scan_out_in  input  1  wrapper scan_out; used only with the optional feature.
busy  output  1  high in SHIFT and CAPTURE.
done  output  1  high in DONE.
signature  output  8  current MISR value.
pass  output  1  done && (signature == GOLDEN_SIG).

Behaviour:
- Reset (reset==0 at a clk edge), from any state including mid-run:
  - state=IDLE, lfsr=LFSR_SEED, misr=0, bit counter=0, pattern counter=0.
  - All outputs 0.
- FSM states: IDLE, SHIFT, CAPTURE, DONE.
- IDLE/DONE with start=1: go to SHIFT; lfsr=LFSR_SEED, misr=0, counters=0. In DONE with start=0, stay in DONE and hold signature.
- start while busy is ignored.
- SHIFT:
  - scan_enable=1; scan_in=lfsr[CHAIN_LEN-1-bitcnt], i.e. MSB first.
  - After CHAIN_LEN cycles the chain holds the pattern (A=lfsr[7:4], B=lfsr[3:0]). Go to CAPTURE when bitcnt==CHAIN_LEN-1.
- CAPTURE (1 cycle):
  - scan_enable=1, scan_in=0. The ALU output is combinationally valid from the chain contents.
  - On the clock edge: misr <= {misr[6:0], misr[7]^misr[5]^misr[4]^misr[3]} ^ {3'b000, zero_flag_in, result_in}.
  - lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; pattern counter +1.
  - If this was the last pattern (counter==NUM_PATTERNS-1) go to DONE, else go to SHIFT.
  - The junk bit shifted in during CAPTURE is fully overwritten by the next SHIFT.
- opcode = pattern counter[2:0]; held constant through SHIFT and CAPTURE of each pattern. Driven 0 in IDLE and DONE.
- Latency: start accepted at edge 0; done rises NUM_PATTERNS*(CHAIN_LEN+1) cycles later.
- scan_enable and scan_in are registered-state decodes only; no combinational path from any input.
- Counters never wrap mid-run. The pattern counter is sized ceil(log2(NUM_PATTERNS))+1.

Optional Feature:
SCAN_BIST_OUTCOMP_EN
- Defined: during every SHIFT cycle misr <= misr ^ {scan_out_in, 7'b0}. This compacts the chain's serial unload, so stuck-at faults on the chain itself alter the signature.
- Undefined: scan_out_in is unused and the MISR updates only in CAPTURE, exactly as above.
- The golden value differs between builds.

Test Plan:
- Reset mid-SHIFT (reset=0 for one edge) -> next cycle state IDLE; scan_enable, busy, done, signature, pass all 0.
- NUM_PATTERNS=1, LFSR_SEED=8'hA5, start pulse -> scan_in over 8 cycles = 1,0,1,0,0,1,0,1. scan_enable high for 9 cycles, opcode=0, done high on cycle 10.
- Same run, ALU stub result_in=0, zero_flag_in=1, feature off -> signature=8'h10; pass=1 when GOLDEN_SIG=8'h10, pass=0 when GOLDEN_SIG=8'h00.
- NUM_PATTERNS=2 -> second pattern scan_in = 0,1,0,0,1,0,1,0 (lfsr=8'h4A), opcode=1, done after 18 cycles.
- start held high during run, then start in DONE -> run not restarted while busy. A new run begins from DONE with misr cleared and lfsr=LFSR_SEED, giving an identical signature.
- SCAN_BIST_OUTCOMP_EN defined, scan_out_in forced 1 -> signature differs from the feature-off run with the same stub.
